// File: rtl/fetch_unit_if.sv
// Handshake bundles for the fetch stage: instruction memory
// request/response channel and the decode-facing channel.
interface imem_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

interface dec_if;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_fault;

  modport master (
    output dec_valid,
    output dec_instr,
    output dec_pc,
    output dec_fault,
    input  dec_ready
  );

  modport slave (
    input  dec_valid,
    input  dec_instr,
    input  dec_pc,
    input  dec_fault,
    output dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with prefetch FIFO and redirect flush.
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_flushed counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  imem_if.master      imem,
  dec_if.master       dec,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {RUN, FAULT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] pending, discard;
  ent_t          fifo [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [NW-1:0] count;

  logic        req_valid;
  logic        req_fire;
  logic        rsp_drop;
  logic        rsp_keep;
  logic        pop;
  logic        misaligned;
  logic [31:0] rsp_pc;

  assign req_fire   = req_valid & imem.imem_req_ready;
  assign rsp_drop   = imem.imem_rsp_valid &
                      (redirect_valid | (discard != '0));
  assign rsp_keep   = imem.imem_rsp_valid & ~rsp_drop;
  assign pop        = (count != '0) & dec.dec_ready;
  assign misaligned = redirect_pc[1:0] != 2'b00;
  // Oldest kept request sits 4*pending bytes behind fetch_pc.
  assign rsp_pc     = fetch_pc - (32'(pending) << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid)
      state_d = misaligned ? FAULT : RUN;
  end

  always_comb begin
    req_valid = 1'b0;
    unique case (state_q)
      RUN: req_valid = rst_n && !redirect_valid &&
        (int'(pending) + int'(count) < FIFO_DEPTH) &&
        (int'(pending) + int'(discard) < MAX_OUTSTANDING);
      FAULT: req_valid = 1'b0;
    endcase
  end

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      pending  <= '0;
      discard  <= '0;
    end else if (redirect_valid) begin
      if (!misaligned)
        fetch_pc <= redirect_pc;
      pending <= '0;
      discard <= discard + pending -
                 CW'(imem.imem_rsp_valid);
    end else begin
      if (req_fire)
        fetch_pc <= fetch_pc + 32'd4;
      pending <= pending + CW'(req_fire) - CW'(rsp_keep);
      discard <= discard - CW'(rsp_drop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      if (misaligned) begin
        fifo[0] <= '{pc: redirect_pc, instr: 32'h0,
                     fault: 1'b1};
        wr_ptr  <= AW'(1);
        count   <= NW'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (rsp_keep) begin
        fifo[wr_ptr] <= '{pc: rsp_pc,
                          instr: imem.imem_rsp_data,
                          fault: 1'b0};
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + NW'(rsp_keep) - NW'(pop);
    end
  end

  always_comb begin
    dec.dec_valid = count != '0;
    dec.dec_pc    = '0;
    dec.dec_instr = '0;
    dec.dec_fault = 1'b0;
    if (count != '0) begin
      dec.dec_pc    = fifo[rd_ptr].pc;
      dec.dec_instr = fifo[rd_ptr].instr;
      dec.dec_fault = fifo[rd_ptr].fault;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(rsp_keep);
      perf_flushed <= perf_flushed + 32'(rsp_drop) +
        (redirect_valid ? 32'(count) - 32'(pop) : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model with variable
// latency, expected decode stream queue, redirect scenarios.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_if imem ();
  dec_if  dec ();

  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  fetch_unit #(
    .RESET_PC(32'h0),
    .FIFO_DEPTH(2),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem(imem),
    .dec(dec),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  mreq_t mq[$];
  exp_t  eq[$];

  int n_chk = 0;
  int n_fail = 0;
  int cnt = 0;
  int lat = 1;
  int n_req = 0;
  int n_deliv = 0;
  int first_req = -1;
  int first_dec = -1;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] last_pc = 32'h0;
  logic        last_fault = 1'b0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdata(logic [31:0] a);
    return a ^ 32'h1357_9bdf;
  endfunction

  // Called at negedge: all inputs for the next edge are settled.
  task automatic sample();
    exp_t e;
    if (dec.dec_valid && first_dec < 0)
      first_dec = cnt;
    if (dec.dec_valid && dec.dec_ready) begin
      if (eq.size() == 0) begin
        check("dec_unexpected", 32'd1, 32'd0);
      end else begin
        e = eq.pop_front();
        check("dec_pc", dec.dec_pc, e.pc);
        check("dec_instr", dec.dec_instr, e.instr);
        check("dec_fault", 32'(dec.dec_fault), 32'(e.fault));
      end
      n_deliv++;
      last_pc = dec.dec_pc;
      last_fault = dec.dec_fault;
    end
    if (imem.imem_rsp_valid && mq.size() > 0)
      void'(mq.pop_front());
    if (redirect_valid) begin
      eq.delete();
      if (redirect_pc[1:0] != 2'b00)
        eq.push_back('{redirect_pc, 32'h0, 1'b1});
      else
        exp_addr = redirect_pc;
    end
    if (imem.imem_req_valid && imem.imem_req_ready) begin
      check("req_addr", imem.imem_req_addr, exp_addr);
      if (first_req < 0)
        first_req = cnt;
      mq.push_back('{exp_addr, cnt + lat});
      eq.push_back('{exp_addr, mdata(exp_addr), 1'b0});
      exp_addr += 32'd4;
      n_req++;
    end
  endtask

  task automatic drive_rsp();
    if (mq.size() > 0 && mq[0].due <= cnt) begin
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data  = mdata(mq[0].addr);
    end else begin
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cnt++;
    drive_rsp();
  endtask

  task automatic redirect(logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_deliv(int n, string tag);
    int k = 0;
    while (n_deliv < n && k < 200) begin
      step();
      k++;
    end
    if (n_deliv < n)
      check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int d0;
    int n0;
    int k;
    logic [31:0] fl0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data = 32'h0;
    dec.dec_ready = 1'b1;
    fl0 = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
    check("rst_dec_valid", 32'(dec.dec_valid), 32'd0);
    check("rst_dec_instr", dec.dec_instr, 32'h0);
    check("rst_dec_pc", dec.dec_pc, 32'h0);
    check("rst_dec_fault", 32'(dec.dec_fault), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_flushed", perf_flushed, 32'h0);
`endif
    rst_n = 1'b1;

    // Free-running fetch from reset
    repeat (12) step();
    check("first_dec_latency", 32'(first_dec - first_req), 32'd2);
    check("stream_progress", 32'(n_deliv >= 3), 32'd1);

    // Decode stalled: only FIFO_DEPTH requests go out
    dec.dec_ready = 1'b0;
    redirect(32'h0);
    n0 = n_req;
    repeat (10) step();
    check("stall_reqs", 32'(n_req - n0), 32'd2);
    check("stall_req_valid", 32'(imem.imem_req_valid), 32'd0);
    check("stall_held", 32'(eq.size()), 32'd2);
    dec.dec_ready = 1'b1;
    k = 0;
    while (n_req < n0 + 3 && k < 50) begin
      step();
      k++;
    end
    check("resume_req", 32'(n_req >= n0 + 3), 32'd1);

    // Redirect with two requests in flight
    lat = 4;
    redirect(32'h40);
    k = 0;
    while (!(mq.size() == 2 && mq[0].addr == 32'h40 &&
             !imem.imem_rsp_valid && !dec.dec_valid) && k < 50) begin
      step();
      k++;
    end
    check("two_pending", 32'(mq.size()), 32'd2);
`ifdef FETCH_PERF_CNT_EN
    fl0 = perf_flushed;
`endif
    redirect(32'h100);
    d0 = n_deliv;
    wait_deliv(d0 + 1, "deliv_100");
    check("redir_first_pc", last_pc, 32'h100);
`ifdef FETCH_PERF_CNT_EN
    check("perf_flushed_2", perf_flushed - fl0, 32'd2);
`endif

    // Redirect coinciding with a response and a decode pop
    lat = 1;
    k = 0;
    while (!(imem.imem_rsp_valid && dec.dec_valid) && k < 50) begin
      step();
      k++;
    end
    check("rsp_and_pop", 32'(imem.imem_rsp_valid && dec.dec_valid),
          32'd1);
    redirect(32'h180);
    d0 = n_deliv;
    wait_deliv(d0 + 1, "deliv_180");
    check("redir_rsp_pc", last_pc, 32'h180);

    // Misaligned target enters FAULT
    redirect(32'h102);
    d0 = n_deliv;
    n0 = n_req;
    repeat (8) step();
    check("fault_count", 32'(n_deliv - d0), 32'd1);
    check("fault_flag", 32'(last_fault), 32'd1);
    check("fault_pc", last_pc, 32'h102);
    check("fault_no_req", 32'(n_req - n0), 32'd0);
    check("fault_dec_idle", 32'(dec.dec_valid), 32'd0);
    redirect(32'h200);
    d0 = n_deliv;
    wait_deliv(d0 + 1, "deliv_200");
    check("fault_exit_pc", last_pc, 32'h200);

    // Address wrap at top of memory
    redirect(32'hffff_fff8);
    d0 = n_deliv;
    wait_deliv(d0 + 3, "deliv_wrap");
    check("wrap_pc", last_pc, 32'h0);

    // Park in FAULT and drain everything
    redirect(32'h3);
    k = 0;
    while ((eq.size() != 0 || mq.size() != 0) && k < 50) begin
      step();
      k++;
    end
    check("drain_exp", 32'(eq.size()), 32'd0);
    check("drain_mem", 32'(mq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
